// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes (also used by the control decoder),
// loader request kinds and the loader FSM state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    K_RTYPE   = 3'd0,
    K_LW      = 3'd1,
    K_SW      = 3'd2,
    K_BEQ     = 3'd3,
    K_ADDI    = 3'd4,
    K_J       = 3'd5,
    K_JAL     = 3'd6,
    K_ILLEGAL = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational field packer: request kind + fields -> 32-bit R/I/J word.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind_e'(kind))
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_LW:    word = {OP_LW,    rs, rt, imm};
      K_SW:    word = {OP_SW,    rs, rt, imm};
      K_BEQ:   word = {OP_BEQ,   rs, rt, imm};
      K_ADDI:  word = {OP_ADDI,  rs, rt, imm};
      K_J:     word = {OP_J,     target};
      K_JAL:   word = {OP_JAL,   target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams field-level instruction requests into instruction memory, one
// encoded word per cycle, one cycle after each accepted request.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] LAST_SLOT = '1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              pend_q, last_q;
  logic [31:0]       word_q;
  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              accept, arm;

  mips_instr_pack u_pack (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (pk_word),
    .illegal(pk_illegal)
  );

  // Stall once the pending write is the program's last or fills the top slot.
  assign in_ready  = (state == S_LOAD) && !(pend_q && (last_q || ptr == LAST_SLOT));
  assign accept    = in_valid && in_ready;
  assign arm       = start && (state != S_LOAD);
  assign load_done = (state == S_DONE);

  // Reset suppresses a write combinationally so it never escapes that cycle.
  assign imem_we    = pend_q && !reset;
  assign imem_addr  = imem_we ? ptr : '0;
  assign imem_wdata = imem_we ? word_q : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (accept && pk_illegal)               state_nxt = S_ERROR;
        else if (pend_q && last_q)              state_nxt = S_DONE;
        else if (pend_q && ptr == LAST_SLOT)    state_nxt = S_ERROR;
      end
      default: if (start)                       state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      last_q       <= 1'b0;
      word_q       <= '0;
      ptr          <= BASE;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (arm) begin
      pend_q       <= 1'b0;
      ptr          <= BASE;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (state == S_LOAD) begin
      pend_q <= accept && !pk_illegal;
      if (accept) begin
        word_q <= pk_word;
        last_q <= in_last;
      end
      if (accept && pk_illegal) err_illegal <= 1'b1;
      if (pend_q) begin
        word_count <= word_count + 1'b1;
        // The pointer parks on the top slot rather than wrapping.
        if (ptr != LAST_SLOT)  ptr <= ptr + 1'b1;
        else if (!last_q)      err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench: main loader (ADDR_W=8) plus a tiny ADDR_W=2 instance for overflow.
module tb_instr_encode_loader;

  logic clk = 1'b0;
  logic reset, start, in_valid, start2, in_valid2;
  logic [2:0] in_kind;
  logic [4:0] in_rs, in_rt, in_rd, in_shamt;
  logic [5:0] in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic in_last;

  logic in_ready, imem_we, load_done, err_illegal, err_overflow;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] word_count;

  logic in_ready2, imem_we2, load_done2, err_illegal2, err_overflow2;
  logic [1:0] imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0] word_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .load_done(load_done),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .word_count(word_count2), .load_done(load_done2),
    .err_illegal(err_illegal2), .err_overflow(err_overflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                     input logic [25:0] tg, input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0;
    in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, word_count, load_done, err_illegal, err_overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0h wd=%h cnt=%0d done=%b ei=%b eo=%b, want all 0",
               in_ready, imem_we, imem_addr, imem_wdata, word_count, load_done, err_illegal, err_overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_start();
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h20080005) begin
      n_bad++; $display("FAIL single_write: got we=%b addr=%0d wd=%h want 1/0/20080005", imem_we, imem_addr, imem_wdata);
    end
    tick();
    n_cmp++;
    if (load_done !== 1'b1 || word_count !== 9'd1 || imem_we !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got done=%b cnt=%0d we=%b want 1/1/0", load_done, word_count, imem_we);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    req(3'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h8FA80004) begin
      n_bad++; $display("FAIL b2b_lw: got we=%b addr=%0d wd=%h want 1/0/8FA80004", imem_we, imem_addr, imem_wdata);
    end
    req(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h01095020) begin
      n_bad++; $display("FAIL b2b_rtype: got we=%b addr=%0d wd=%h want 1/1/01095020", imem_we, imem_addr, imem_wdata);
    end
    req(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd2 || imem_wdata !== 32'h1109FFFF) begin
      n_bad++; $display("FAIL b2b_beq: got we=%b addr=%0d wd=%h want 1/2/1109FFFF", imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_jumps();
    req(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0);
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd3 || imem_wdata !== 32'h08000010) begin
      n_bad++; $display("FAIL jump_j: got we=%b addr=%0d wd=%h want 1/3/08000010", imem_we, imem_addr, imem_wdata);
    end
    req(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100, 1'b1);
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd4 || imem_wdata !== 32'h0C000100 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL jump_jal: got we=%b addr=%0d wd=%h rdy=%b want 1/4/0C000100/0",
                        imem_we, imem_addr, imem_wdata, in_ready);
    end
    tick();
    n_cmp++;
    if (load_done !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || word_count !== 9'd5) begin
      n_bad++; $display("FAIL jump_done: got done=%b rdy=%b we=%b cnt=%0d want 1/0/0/5",
                        load_done, in_ready, imem_we, word_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    do_start();
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0) begin
      n_bad++; $display("FAIL illegal_pre: got we=%b addr=%0d want 1/0", imem_we, imem_addr);
    end
    req(3'd7, 5'd1, 5'd2, 5'd3, 6'd4, 16'h1234, 26'h55, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (imem_we !== 1'b0 || err_illegal !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0 || word_count !== 9'd1) begin
      n_bad++; $display("FAIL illegal_err: got we=%b ei=%b rdy=%b done=%b cnt=%0d want 0/1/0/0/1",
                        imem_we, err_illegal, in_ready, load_done, word_count);
    end
    do_start();
    n_cmp++;
    if (err_illegal !== 1'b0 || word_count !== 9'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL illegal_restart: got ei=%b cnt=%0d rdy=%b want 0/0/1", err_illegal, word_count, in_ready);
    end
    req(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hAC640008) begin
      n_bad++; $display("FAIL illegal_base: got we=%b addr=%0d wd=%h want 1/0/AC640008", imem_we, imem_addr, imem_wdata);
    end
    tick();
  endtask

  task automatic test_overflow();
    int writes;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (imem_we2 !== 1'b1 || imem_addr2 !== 2'(i) || imem_wdata2 !== (32'h20080000 | 32'(i))) begin
        n_bad++; $display("FAIL ovf_write%0d: got we=%b addr=%0d wd=%h want 1/%0d/%h",
                          i, imem_we2, imem_addr2, imem_wdata2, i, 32'h20080000 | 32'(i));
      end
      in_imm = 16'(i + 1);
    end
    n_cmp++;
    if (in_ready2 !== 1'b0 || err_overflow2 !== 1'b0) begin
      n_bad++; $display("FAIL ovf_stall: got rdy=%b eo=%b want 0/0", in_ready2, err_overflow2);
    end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_we2 === 1'b1) writes++;
    end
    n_cmp++;
    if (err_overflow2 !== 1'b1 || writes != 0 || word_count2 !== 3'd4 || in_ready2 !== 1'b0 || load_done2 !== 1'b0) begin
      n_bad++; $display("FAIL ovf_err: got eo=%b extra_writes=%0d cnt=%0d rdy=%b done=%b want 1/0/4/0/0",
                        err_overflow2, writes, word_count2, in_ready2, load_done2);
    end
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset_midload();
    do_start();
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL midreset_we: got %b want 0", imem_we); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_we !== 1'b0 || word_count !== 9'd0 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      n_bad++; $display("FAIL midreset_idle: got we=%b cnt=%0d rdy=%b done=%b want 0/0/0/0",
                        imem_we, word_count, in_ready, load_done);
    end
    tick();
    n_cmp++;
    if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midreset_quiet: got we=%b rdy=%b want 0/0", imem_we, in_ready);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_jumps();
    test_illegal();
    test_overflow();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
